// File: rtl/raybox_zero_pkg.sv
// Shared definitions for the raybox-zero SPI register controller: register
// indices, reset defaults, receiver states and frame length derivation.
package raybox_zero_pkg;

  localparam int RZ_ADDR_W   = 4;
  localparam int RZ_DATA_W   = 24;
  localparam int RZ_NUM_REGS = 4;

  localparam int REG_SKY   = 0;
  localparam int REG_FLOOR = 1;
  localparam int REG_OPTS  = 2;
  localparam int REG_VINF  = 3;

  localparam logic [RZ_DATA_W-1:0] DEF_RESET_VAL = 24'h000000;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_DONE  = 2'd2
  } rx_state_t;

  function automatic int frame_len(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, with a third flop
// providing rise/fall detection on the synchronised copy.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // synchroniser chain plus edge-history flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI-slave register bank with vblank-committed double buffering.
// Optional macro SPI_REG_IMMEDIATE_EN: address MSB selects an immediate write.
module spi_reg_ctrl
  import raybox_zero_pkg::*;
#(
  parameter int                 ADDR_W    = RZ_ADDR_W,
  parameter int                 DATA_W    = RZ_DATA_W,
  parameter int                 NUM_REGS  = RZ_NUM_REGS,
  parameter logic [DATA_W-1:0]  RESET_VAL = DATA_W'(DEF_RESET_VAL)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spi_sclk,
  input  logic                         spi_mosi,
  input  logic                         spi_ss_n,
  input  logic                         frame_start,
  output logic [NUM_REGS*DATA_W-1:0]   reg_data,
  output logic [NUM_REGS-1:0]          pending,
  output logic                         reg_updated,
  output logic                         frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
`ifdef SPI_REG_IMMEDIATE_EN
  localparam int IDX_W     = ADDR_W - 1;
`else
  localparam int IDX_W     = ADDR_W;
`endif

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_ss_sync, w_ss_rise, w_ss_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
  logic w_unused_edges;

  rx_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [FRAME_LEN-1:0] r_shift, w_shift_nxt;
  logic                 w_frame_end;
  logic                 w_short;

  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_data;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_imm;
  logic                 w_valid;

  logic [DATA_W-1:0]    r_live  [NUM_REGS];
  logic [DATA_W-1:0]    r_stage [NUM_REGS];
  logic [NUM_REGS-1:0]  r_pending;
  logic                 r_reg_updated;
  logic                 r_frame_err;

  spi_sync_edge u_sclk_sync (
    .clk(clk), .reset(reset), .i_async(spi_sclk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge u_ss_sync (
    .clk(clk), .reset(reset), .i_async(spi_ss_n),
    .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge u_mosi_sync (
    .clk(clk), .reset(reset), .i_async(spi_mosi),
    .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused_edges = &{1'b0, w_sclk_sync, w_sclk_fall, w_mosi_rise, w_mosi_fall};

  // receiver state, bit counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // receiver next-state: an ss_n rise always ends the frame, whatever the SCLK is doing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_frame_end = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_ss_fall) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_state_nxt = RX_SHIFT;
        end else begin
          w_state_nxt = RX_IDLE;
        end
      end
      RX_SHIFT: begin
        if (w_ss_rise) begin
          w_short     = 1'b1;
          w_state_nxt = RX_IDLE;
        end else if (w_sclk_rise && !w_ss_sync) begin
          w_shift_nxt = {r_shift[FRAME_LEN-2:0], w_mosi_sync};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
            w_state_nxt = RX_DONE;
          end else begin
            w_state_nxt = RX_SHIFT;
          end
        end else begin
          w_state_nxt = RX_SHIFT;
        end
      end
      RX_DONE: begin
        if (w_ss_rise) begin
          w_frame_end = 1'b1;
          w_state_nxt = RX_IDLE;
        end else begin
          w_state_nxt = RX_DONE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  assign w_addr = r_shift[FRAME_LEN-1 -: ADDR_W];
  assign w_data = r_shift[DATA_W-1:0];
`ifdef SPI_REG_IMMEDIATE_EN
  assign w_imm  = w_addr[ADDR_W-1];
  assign w_idx  = w_addr[IDX_W-1:0];
`else
  assign w_imm  = 1'b0;
  assign w_idx  = w_addr;
`endif
  assign w_valid = ({1'b0, w_idx} < (IDX_W + 1)'(NUM_REGS));

  // register bank; a same-cycle staging write lands after the commit so it stays pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_live[i]  <= RESET_VAL;
        r_stage[i] <= RESET_VAL;
      end
      r_pending     <= '0;
      r_reg_updated <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_err   <= w_short | (w_frame_end & ~w_valid);
      r_reg_updated <= (frame_start & (|r_pending)) | (w_frame_end & w_valid & w_imm);
      if (frame_start) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_pending[i]) begin
            r_live[i] <= r_stage[i];
          end
        end
        r_pending <= '0;
      end
      if (w_frame_end && w_valid) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_idx == IDX_W'(i)) begin
            r_stage[i] <= w_data;
            if (w_imm) begin
              r_live[i]    <= w_data;
              r_pending[i] <= 1'b0;
            end else begin
              r_pending[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_data[g*DATA_W +: DATA_W] = r_live[g];
  end

  assign pending     = r_pending;
  assign reg_updated = r_reg_updated;
  assign frame_err   = r_frame_err;

endmodule
